// File: rtl/aes0_pkg.sv
// rtl/aes0_pkg.sv - shared types for the AES0 ciphertext buffer; layout depends on AES0_CT_BUF_CYCLE_TAG_EN
package aes0_pkg;
    typedef logic [63:0] ct_word_t;

`ifdef AES0_CT_BUF_CYCLE_TAG_EN
    typedef struct packed {
        logic [127:0] ct;
        logic [31:0]  cycle;
    } ct_entry_t;
    localparam int AES0_CT_WORDS = 3;
`else
    typedef struct packed {
        logic [127:0] ct;
    } ct_entry_t;
    localparam int AES0_CT_WORDS = 2;
`endif

    typedef logic [1:0] word_idx_t;
    localparam word_idx_t AES0_CT_LAST_WORD = word_idx_t'(AES0_CT_WORDS - 1);
endpackage

// File: rtl/aes0_ct_fifo_mem.sv
// rtl/aes0_ct_fifo_mem.sv - ciphertext entry storage, one write port and an asynchronous read port
module aes0_ct_fifo_mem
    import aes0_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ct_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output ct_entry_t     rdata
);
    // Data is qualified by the owner's count, so the array carries no reset.
    ct_entry_t mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/aes0_ct_buffer.sv
// rtl/aes0_ct_buffer.sv - AES0 ciphertext result FIFO drained as 64-bit read words; cycle tag under AES0_CT_BUF_CYCLE_TAG_EN
module aes0_ct_buffer
    import aes0_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int CT_WIDTH = 128,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CT_WIDTH-1:0] ct_i,
    input  logic                ct_valid_i,
    input  logic [31:0]         cycle_i,
    input  logic                flush_i,
    input  logic                lock_i,
    input  logic                pop_i,
    output ct_word_t            data_o,
    output logic [CW-1:0]       count_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                overflow_o
);
    logic          ct_valid_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    word_idx_t     word_idx_q;
    logic          overflow_q;

    logic      capture;
    logic      is_empty;
    logic      is_full;
    logic      pop_ok;
    logic      pop_last;
    logic      accept;
    ct_entry_t wr_entry;
    ct_entry_t head;

    assign capture  = ct_valid_i & ~ct_valid_q;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign pop_ok   = pop_i & ~lock_i & ~is_empty;
    assign pop_last = pop_ok & (word_idx_q == AES0_CT_LAST_WORD);
    // A last-word pop frees the head slot in time for a same-cycle capture.
    assign accept   = capture & (~is_full | pop_last);

    assign wr_entry.ct = ct_i;
`ifdef AES0_CT_BUF_CYCLE_TAG_EN
    assign wr_entry.cycle = cycle_i;
`else
    logic unused_cycle;
    assign unused_cycle = ^cycle_i;
`endif

    aes0_ct_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i (clk_i),
        .we    (accept & ~flush_i),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ct_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ct_valid_q <= ct_valid_i;
            if (flush_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                word_idx_q <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (accept) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_last) begin
                    rd_ptr_q   <= rd_ptr_q + AW'(1);
                    word_idx_q <= '0;
                end else if (pop_ok) begin
                    word_idx_q <= word_idx_q + 2'd1;
                end
                if (accept && !pop_last) begin
                    count_q <= count_q + CW'(1);
                end else if (pop_last && !accept) begin
                    count_q <= count_q - CW'(1);
                end
                if (capture && !accept) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (!is_empty && !lock_i) begin
            case (word_idx_q)
                2'd0:    data_o = head.ct[63:0];
                2'd1:    data_o = head.ct[127:64];
`ifdef AES0_CT_BUF_CYCLE_TAG_EN
                2'd2:    data_o = {32'b0, head.cycle};
`endif
                default: data_o = '0;
            endcase
        end
    end

    assign count_o    = count_q;
    assign empty_o    = is_empty;
    assign full_o     = is_full;
    assign overflow_o = overflow_q;
endmodule

// File: doc/aes0_ct_buffer.md
# aes0_ct_buffer

Downstream result stage for the AES0 peripheral. Captures each completed 128-bit ciphertext from the AES core on the rising edge of its done level, queues it in a small FIFO, and drains it to the AXI-Lite read path as sequential 64-bit words. Lets software issue back-to-back encryptions without losing results that have not yet been read.

## Interface
Parameters:
- DEPTH, 4, number of ciphertext entries; power of two, ≥2
- CT_WIDTH, 128, ciphertext width; fixed at 128, kept for readability

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- ct_i  in  128  ciphertext from AES core
- ct_valid_i  in  1  AES done level; capture on its rising edge
- cycle_i  in  32  encryption cycle count from the AES counter
- flush_i  in  1  one-cycle pulse; empties the FIFO and clears overflow
- lock_i  in  1  register-lock bit; when 1, reads return 0 and pops are ignored
- pop_i  in  1  one-cycle pulse; advance to the next read word
- data_o  out  64  current read word
- count_o  out  $clog2(DEPTH)+1  number of occupied entries
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH
- overflow_o  out  1  sticky flag: a capture was dropped

## Operation
- Edge detect: ct_valid_q registers ct_valid_i. A capture occurs when ct_valid_i & ~ct_valid_q. A level held high yields exactly one capture.
- Capture writes {ct_i, cycle_i} at the write pointer, increments the write pointer (mod DEPTH) and increments count.
- Capture while full (and not freed in the same cycle): entry dropped, overflow_o set, pointers unchanged.
- Word sequence per entry, via word_idx:
  - 0 → ct[63:0]
  - 1 → ct[127:64]
  - 2 → {32'b0, cycle} (only when the macro is enabled)
- pop_i on a non-last word increments word_idx.
- pop_i on the last word resets word_idx to 0, increments the read pointer (mod DEPTH) and decrements count.
- pop_i while empty or while lock_i=1: ignored, no state change.
- data_o is combinational from the head entry and word_idx. It is 0 when empty or when lock_i=1.
- Capture and a last-word pop in the same cycle:
  - Both take effect; count unchanged.
  - When full, the capture is accepted into the slot being freed; no overflow.
- flush_i has priority over capture and pop in the same cycle:
  - Pointers, count and word_idx are cleared; overflow_o is cleared.
  - A coincident capture is discarded.
- lock_i does not block captures.

## Timing
- Reset values: data_o=0, count_o=0, empty_o=1, full_o=0, overflow_o=0. Internally: pointers=0, word_idx=0, ct_valid_q=0.
- Edge seen in cycle N → entry written at the end of N → empty_o low and data_o valid in N+1.
- pop_i in cycle N → data_o shows the next word in N+1.
- Status outputs are registered-state derived and update the cycle after the causing event.
- Reset asserted mid-drain clears everything immediately (asynchronous). Queued results are lost.
- Pointers wrap from DEPTH-1 to 0.
- The count width holds the value DEPTH.

## Configuration
- AES0_CT_BUF_CYCLE_TAG_EN defined:
  - Each entry stores cycle_i (160 bits per entry).
  - Three words per entry; the last word is index 2.
- Not defined:
  - cycle_i is unused and no storage is kept for it.
  - Two words per entry; the last word is index 1.

## Structure
- aes0_pkg holds:
  - ct_word_t (64-bit word)
  - ct_entry_t (struct {ct, cycle tag under macro})
  - AES0_CT_WORDS constant (2 or 3 per the macro)
  - word index typedef
- One sub-module, aes0_ct_fifo_mem: DEPTH×ct_entry_t storage with a write port and an asynchronous read port. It has no reset on its data.
- Pointers, count, word_idx, edge detect and flags live in aes0_ct_buffer.

## Test plan
- Reset, then a single ct_valid_i rise with ct_i=128'h0011…EEFF, cycle_i=32'd21 → next cycle count_o=1, data_o=64'h8899AABBCCDDEEFF. After pop, data_o=64'h0011223344556677. With the macro: after a second pop, data_o=64'h15; after a third pop, empty_o=1 and data_o=0.
- Hold ct_valid_i high 10 cycles → exactly one capture, count_o=1.
- Five captures with DEPTH=4 and no pops → full_o=1, overflow_o=1, count_o=4. Draining returns the first four ciphertexts in order.
- Full FIFO, capture rise in the same cycle as a last-word pop → count_o stays 4, overflow_o stays 0. The new entry is read last.
- lock_i=1 with one entry queued → data_o=0 and pops are ignored. After lock_i drops, the original low word is still presented.
- flush_i in the same cycle as a capture rise, with 2 entries queued → count_o=0, empty_o=1, overflow_o=0, no entry retained.
